// File: rtl/ahb_apb_bridge.sv
// AHB-to-APB bridge on a single PCLK domain, with NSLV one-hot APB slaves selected from an
// HADDR index field. It returns an AHB ERROR for unmapped slaves and for APB ready timeouts.
module ahb_apb_bridge #(
  parameter int unsigned NSLV    = 4,
  parameter int unsigned SEL_LSB = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [31:0]        HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic               HRESP,
  output logic [31:0]        HRDATA,
  output logic [31:0]        PADDR,
  output logic               PWRITE,
  output logic [31:0]        PWDATA,
  output logic               PENABLE,
  output logic [NSLV-1:0]    PSEL,
  input  logic [32*NSLV-1:0] PRDATA_S,
  input  logic [NSLV-1:0]    PREADY_S
);

  localparam int unsigned W = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StWlat,
    StSetup,
    StAccess,
    StErr1,
    StErr2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  idx_q, idx_d;
  logic [31:0]   paddr_q, paddr_d;
  logic          pwrite_q, pwrite_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic [31:0]   hrdata_q, hrdata_d;
  logic [31:0]   cnt_q, cnt_d;

  logic [W-1:0]  haddr_idx;
  logic          mapped;
  logic          accept;
  logic          pready;
  logic [31:0]   prdata_sel;
  logic          unused_ok;

  assign haddr_idx  = HADDR[SEL_LSB +: W];
  assign mapped     = (32'(haddr_idx) < NSLV);
  assign accept     = HSEL & HTRANS[1] & HREADY;
  assign pready     = PREADY_S[idx_q];
  assign prdata_sel = PRDATA_S[32*int'(idx_q) +: 32];

  // Transfer size and the sub-word address bits have no meaning on a 32-bit-only APB.
  assign unused_ok = ^{HSIZE, HTRANS[0], HADDR[1:0]};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle, StErr2: begin
        state_d = StIdle;
        if (accept) begin
          idx_d    = haddr_idx;
          paddr_d  = {HADDR[31:2], 2'b00};
          pwrite_d = HWRITE;
          if (!mapped) begin
            state_d = StErr1;
          end else if (HWRITE) begin
            state_d = StWlat;
          end else begin
            state_d = StSetup;
          end
        end
      end
      StWlat: begin
        // HWDATA is valid only in the data phase, one cycle after the address was accepted.
        pwdata_d = HWDATA;
        state_d  = StSetup;
      end
      StSetup: begin
        cnt_d   = '0;
        state_d = StAccess;
      end
      StAccess: begin
        if (pready) begin
          if (!pwrite_q) begin
            hrdata_d = prdata_sel;
          end
          state_d = StIdle;
        end else if ((TIMEOUT != 0) && (cnt_q == TIMEOUT - 1)) begin
          state_d = StErr1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
      cnt_q    <= cnt_d;
    end
  end

  // All handshake outputs decode from the state register, so an asynchronous reset reaches
  // them immediately.
  always_comb begin
    PSEL = '0;
    if ((state_q == StSetup) || (state_q == StAccess)) begin
      PSEL[idx_q] = 1'b1;
    end
  end

  assign PENABLE   = (state_q == StAccess);
  assign HREADYOUT = (state_q == StIdle) || (state_q == StErr2);
  assign HRESP     = (state_q == StErr1) || (state_q == StErr2);
  assign HRDATA    = hrdata_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;

endmodule
